serialiser_n_to_1: RTL and testbench

Generic, primitive-free, multi-channel parallel-to-serial converter for the video/TMDS output path and other serial links. Runs entirely on the bit clock and takes WIDTH-bit words per channel through a valid/ready handshake. A one-word holding register gives gap-free back-to-back streaming. On underrun it either falls back to an idle level or transmits a fill word. A clock-enable input supports slower bit rates.

---
 rtl/serialiser_pkg.sv | 18 +
 rtl/serialiser_lane.sv | 42 ++++
 rtl/serialiser_n_to_1.sv | 102 ++++++++++
 tb/tb_serialiser_n_to_1.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serialiser_pkg.sv
// Shared types and constants for the N-to-1 serialiser: FSM states, bit-order
// selectors, default geometry and the TMDS fill word.
package serialiser_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam bit LSB_FIRST_ORDER = 1'b1;
  localparam bit MSB_FIRST_ORDER = 1'b0;

  localparam int DEFAULT_WIDTH    = 10;
  localparam int DEFAULT_CHANNELS = 3;

  localparam logic [9:0] TMDS_FILL_WORD = 10'h354;

endpackage

// File: rtl/serialiser_lane.sv
// One serial lane: a one-word holding register feeding a shift register whose
// end bit drives the lane output directly.
module serialiser_lane
  import serialiser_pkg::*;
#(
  parameter int               WIDTH      = DEFAULT_WIDTH,
  parameter bit               LSB_FIRST  = LSB_FIRST_ORDER,
  parameter logic             IDLE_LEVEL = 1'b1,
  parameter logic [WIDTH-1:0] FILL_WORD  = WIDTH'(TMDS_FILL_WORD)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             accept,
  input  logic [WIDTH-1:0] din_word,
  input  logic             load_data,
  input  logic             load_fill,
  input  logic             go_idle,
  input  logic             shift,
  output logic             serial
);

  logic [WIDTH-1:0] hold_reg;
  logic [WIDTH-1:0] shift_reg;

  // Vacated positions refill with IDLE_LEVEL so an empty register reads idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_reg  <= '0;
      shift_reg <= {WIDTH{IDLE_LEVEL}};
    end else begin
      if (accept) hold_reg <= din_word;
      if (load_data)      shift_reg <= hold_reg;
      else if (load_fill) shift_reg <= FILL_WORD;
      else if (go_idle)   shift_reg <= {WIDTH{IDLE_LEVEL}};
      else if (shift)     shift_reg <= LSB_FIRST ? {IDLE_LEVEL, shift_reg[WIDTH-1:1]}
                                                 : {shift_reg[WIDTH-2:0], IDLE_LEVEL};
    end
  end

  assign serial = LSB_FIRST ? shift_reg[0] : shift_reg[WIDTH-1];

endmodule

// File: rtl/serialiser_n_to_1.sv
// Multi-lane parallel-to-serial converter on the bit clock: shared control FSM
// and bit counter, per-lane hold/shift registers, optional fill on underrun.
module serialiser_n_to_1
  import serialiser_pkg::*;
#(
  parameter int               WIDTH      = DEFAULT_WIDTH,
  parameter int               CHANNELS   = DEFAULT_CHANNELS,
  parameter bit               LSB_FIRST  = LSB_FIRST_ORDER,
  parameter logic             IDLE_LEVEL = 1'b1,
  parameter bit               FILL_MODE  = 1'b0,
  parameter logic [WIDTH-1:0] FILL_WORD  = WIDTH'(TMDS_FILL_WORD)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic                      din_valid,
  output logic                      din_ready,
  output logic [CHANNELS-1:0]       serial,
  output logic                      frame_start,
  output logic                      underrun,
  output logic                      busy
);

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          hold_full;

  logic accept;
  logic at_last;
  logic load_data;
  logic load_fill;
  logic go_idle;
  logic shift_en;

  // Handshake: a word transfers on any clk edge where din_valid && din_ready;
  // din_ready is simply "holding register empty" and ignores en.
  assign din_ready = !hold_full;
  assign accept    = din_valid && !hold_full;

  assign at_last   = (state == RUN) && (cnt == LAST);
  assign load_data = en && hold_full && ((state == IDLE) || at_last);
  assign load_fill = en && at_last && !hold_full && FILL_MODE;
  assign go_idle   = en && at_last && !hold_full && !FILL_MODE;
  assign shift_en  = en && (state == RUN) && (cnt != LAST);

  assign busy        = (state == RUN);
  assign frame_start = (state == RUN) && (cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      hold_full <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= load_fill;
      // accept and load_data are exclusive: one needs hold empty, the other full.
      if (accept)         hold_full <= 1'b1;
      else if (load_data) hold_full <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load_data) begin
            state <= RUN;
            cnt   <= '0;
          end
        end
        RUN: begin
          if (en) begin
            if (cnt != LAST) cnt   <= cnt + CW'(1);
            else if (go_idle) state <= IDLE;
            else              cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    serialiser_lane #(
      .WIDTH      (WIDTH),
      .LSB_FIRST  (LSB_FIRST),
      .IDLE_LEVEL (IDLE_LEVEL),
      .FILL_WORD  (FILL_WORD)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .accept    (accept),
      .din_word  (din[c*WIDTH +: WIDTH]),
      .load_data (load_data),
      .load_fill (load_fill),
      .go_idle   (go_idle),
      .shift     (shift_en),
      .serial    (serial[c])
    );
  end

endmodule

// File: tb/tb_serialiser_n_to_1.sv
// Bench for serialiser_n_to_1: two instances (LSB-first/no fill, MSB-first/fill)
// checked every cycle against a bit-queue reference model.
module tb_serialiser_n_to_1;

  localparam int NI = 2;
  localparam int W  = 10;
  localparam int CH = 3;
  localparam int DW = W * CH;
  localparam logic [W-1:0] FILL = 10'h354;

  logic clk;
  logic reset;
  logic en;
  logic [DW-1:0] din_s       [NI];
  logic          valid_s     [NI];
  logic          ready_s     [NI];
  logic [CH-1:0] serial_s    [NI];
  logic          fs_s        [NI];
  logic          under_s     [NI];
  logic          busy_s      [NI];

  // model state: words waiting to be offered, words held, bits still to show
  logic [DW-1:0] src_q  [NI][$];
  logic [DW-1:0] hold_q [NI][$];
  logic [CH-1:0] bits_q [NI][$];
  bit            exp_under [NI];
  logic [W-1:0]  exp_q[$];

  int total;
  int bad;

  serialiser_n_to_1 #(.WIDTH(W), .CHANNELS(CH), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1),
                      .FILL_MODE(1'b0), .FILL_WORD(FILL)) dut_a (
    .clk (clk), .reset (reset), .en (en), .din (din_s[0]), .din_valid (valid_s[0]),
    .din_ready (ready_s[0]), .serial (serial_s[0]), .frame_start (fs_s[0]),
    .underrun (under_s[0]), .busy (busy_s[0]));

  serialiser_n_to_1 #(.WIDTH(W), .CHANNELS(CH), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1),
                      .FILL_MODE(1'b1), .FILL_WORD(FILL)) dut_b (
    .clk (clk), .reset (reset), .en (en), .din (din_s[1]), .din_valid (valid_s[1]),
    .din_ready (ready_s[1]), .serial (serial_s[1]), .frame_start (fs_s[1]),
    .underrun (under_s[1]), .busy (busy_s[1]));

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit lsb_of(input int id);
    return id == 0;
  endfunction

  function automatic bit fill_of(input int id);
    return id == 1;
  endfunction

  function automatic logic [W-1:0] rev(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = x[W-1-i];
    return r;
  endfunction

  function automatic logic [DW-1:0] rep(input logic [W-1:0] w);
    return {CH{w}};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, expv, $time);
    end
  endtask

  // a loaded word becomes W bit-vectors in transmission order
  task automatic push_word(input int id, input logic [DW-1:0] w);
    logic [CH-1:0] v;
    int b;
    for (int i = 0; i < W; i++) begin
      b = lsb_of(id) ? i : W - 1 - i;
      for (int c = 0; c < CH; c++) v[c] = w[c*W + b];
      bits_q[id].push_back(v);
    end
  endtask

  task automatic check_all();
    logic [CH-1:0] es;
    int n;
    for (int id = 0; id < NI; id++) begin
      n  = bits_q[id].size();
      es = (n > 0) ? bits_q[id][0] : {CH{1'b1}};
      chk($sformatf("serial[%0d]", id), 32'(serial_s[id]), 32'(es));
      chk($sformatf("busy[%0d]", id), 32'(busy_s[id]), 32'(n > 0));
      chk($sformatf("frame_start[%0d]", id), 32'(fs_s[id]), 32'(n == W));
      chk($sformatf("din_ready[%0d]", id), 32'(ready_s[id]), 32'(hold_q[id].size() == 0));
      chk($sformatf("underrun[%0d]", id), 32'(under_s[id]), 32'(exp_under[id]));
    end
  endtask

  // driver: offer queued words, clock once, advance the model, then check
  task automatic tick(input logic e);
    bit acc [NI];
    bit was_run;
    en = e;
    for (int id = 0; id < NI; id++) begin
      valid_s[id] = src_q[id].size() > 0;
      din_s[id]   = valid_s[id] ? src_q[id][0] : DW'({$urandom(), $urandom()});
      acc[id]     = valid_s[id] && (hold_q[id].size() == 0);
    end
    @(posedge clk);
    for (int id = 0; id < NI; id++) begin
      exp_under[id] = 1'b0;
      if (e) begin
        if (bits_q[id].size() > 1) begin
          void'(bits_q[id].pop_front());
        end else begin
          was_run = bits_q[id].size() == 1;
          bits_q[id].delete();
          if (hold_q[id].size() > 0) begin
            push_word(id, hold_q[id].pop_front());
          end else if (was_run && fill_of(id)) begin
            push_word(id, rep(FILL));
            exp_under[id] = 1'b1;
          end
        end
      end
      if (acc[id]) begin
        hold_q[id].push_back(din_s[id]);
        void'(src_q[id].pop_front());
      end
    end
    #1;
    check_all();
  endtask

  task automatic ticks(input int n, input logic e);
    for (int i = 0; i < n; i++) tick(e);
  endtask

  // asserting reset must force idle outputs without any clock edge
  task automatic do_reset();
    reset = 1'b1;
    for (int id = 0; id < NI; id++) begin
      src_q[id].delete();
      hold_q[id].delete();
      bits_q[id].delete();
      exp_under[id] = 1'b0;
      valid_s[id]   = 1'b0;
    end
    #1;
    check_all();
    chk("reset_serial_a", 32'(serial_s[0]), 32'h7);
    chk("reset_serial_b", 32'(serial_s[1]), 32'h7);
    #2;
    reset = 1'b0;
  endtask

  // record W consecutive bits of one lane and compare with the scoreboard head
  task automatic capture(input int id, input int lane, input string tag);
    logic [W-1:0] got;
    logic [W-1:0] expw;
    for (int i = 0; i < W; i++) begin
      got[W-1-i] = serial_s[id][lane];
      tick(1'b1);
    end
    expw = exp_q.pop_front();
    chk(tag, 32'(got), 32'(expw));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    en    = 1'b0;
    for (int id = 0; id < NI; id++) begin
      valid_s[id]   = 1'b0;
      din_s[id]     = '0;
      exp_under[id] = 1'b0;
    end
    do_reset();

    // MSB-first word 10'h200 on lane 0 of dut_b: 1 then nine 0s
    src_q[0].push_back(rep(10'h200));
    src_q[1].push_back(rep(10'h200));
    ticks(2, 1'b1);
    chk("msb_first_bit", 32'(serial_s[1][0]), 32'h1);
    exp_q.push_back(10'h200);
    capture(1, 0, "msb_word");

    // reset at bit 5, then a clean restart
    src_q[0].push_back(rep(10'h2C3));
    src_q[1].push_back(rep(10'h2C3));
    ticks(7, 1'b1);
    do_reset();
    src_q[0].push_back(rep(10'h1E5));
    src_q[1].push_back(rep(10'h1E5));
    ticks(2, 1'b1);
    chk("restart_frame_start", 32'(fs_s[1]), 32'h1);
    exp_q.push_back(10'h1E5);
    capture(1, 0, "restart_word");

    // single LSB-first word 10'h2AA on lane 0 of dut_a
    src_q[0].push_back({(DW-W)'({$urandom(), $urandom()}), 10'h2AA});
    ticks(2, 1'b1);
    exp_q.push_back(rev(10'h2AA));
    capture(0, 0, "lsb_word");
    tick(1'b1);
    chk("single_done_idle", 32'(busy_s[0]), 32'h0);

    // three back-to-back words with din_valid held high
    foreach (src_q[id]) begin
      src_q[id].push_back(rep(10'h155));
      src_q[id].push_back(rep(10'h2AA));
      src_q[id].push_back(rep(10'h3FF));
    end
    ticks(45, 1'b1);

    // en low for three cycles at bit 4, with a word accepted meanwhile
    src_q[0].push_back(rep(10'h0F3));
    ticks(6, 1'b1);
    src_q[0].push_back(rep(10'h30C));
    ticks(3, 1'b0);
    chk("accept_while_disabled", 32'(ready_s[0]), 32'h0);
    ticks(25, 1'b1);

    // dut_b keeps filling; a word offered mid-fill starts at the next boundary
    ticks(25, 1'b1);
    src_q[1].push_back(rep(10'h0AB));
    ticks(30, 1'b1);

    // randomized traffic, enable gaps and occasional reset
    for (int i = 0; i < 1500; i++) begin
      for (int id = 0; id < NI; id++)
        if (src_q[id].size() == 0 && $urandom_range(0, 5) == 0)
          src_q[id].push_back(DW'({$urandom(), $urandom()}));
      if ($urandom_range(0, 299) == 0) do_reset();
      tick(1'($urandom_range(0, 4) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
